// File: rtl/mem_stage_if.sv
// Bundle and handshake signals around the memory-access stage.
// "slave" is the stage's own view; "master" is the view of whatever
// surrounds it (execute, data SRAM, writeback, decode, flush control).
interface mem_stage_if #(
    parameter int DATA_W     = 32,
    parameter int CSR_ADDR_W = 14,
    parameter int ECODE_W    = 8
);
    logic                  em_valid;
    logic                  m_allowin;
    logic [DATA_W-1:0]     em_pc;
    logic [DATA_W-1:0]     em_rf_wdata;
    logic                  em_gr_we;
    logic [4:0]            em_dest;
    logic [3:0]            em_res_from_mem;
    logic [DATA_W-1:0]     em_addr;
    logic                  em_ex;
    logic [ECODE_W-1:0]    em_ecode;
    logic                  em_esubcode;
    logic [CSR_ADDR_W-1:0] em_csr_addr;
    logic                  em_csr_we;
    logic [DATA_W-1:0]     em_csr_wmask;
    logic [DATA_W-1:0]     em_csr_wdata;

    logic [DATA_W-1:0]     data_sram_rdata;
    logic                  data_sram_data_ok;

    logic                  w_allowin;
    logic                  mw_valid;
    logic [DATA_W-1:0]     mw_pc;
    logic [DATA_W-1:0]     mw_rf_wdata;
    logic                  mw_gr_we;
    logic [4:0]            mw_dest;
    logic                  mw_ex;
    logic [ECODE_W-1:0]    mw_ecode;
    logic                  mw_esubcode;
    logic [CSR_ADDR_W-1:0] mw_csr_addr;
    logic                  mw_csr_we;
    logic [DATA_W-1:0]     mw_csr_wmask;
    logic [DATA_W-1:0]     mw_csr_wdata;

    logic [4:0]            md_fwd_dest;
    logic [DATA_W-1:0]     md_fwd_data;
    logic                  md_fwd_busy;

    logic                  ex_en;
    logic                  m_ex;

    modport slave (
        input  em_valid, em_pc, em_rf_wdata, em_gr_we, em_dest, em_res_from_mem,
               em_addr, em_ex, em_ecode, em_esubcode, em_csr_addr, em_csr_we,
               em_csr_wmask, em_csr_wdata,
               data_sram_rdata, data_sram_data_ok, w_allowin, ex_en,
        output m_allowin, mw_valid, mw_pc, mw_rf_wdata, mw_gr_we, mw_dest,
               mw_ex, mw_ecode, mw_esubcode, mw_csr_addr, mw_csr_we,
               mw_csr_wmask, mw_csr_wdata,
               md_fwd_dest, md_fwd_data, md_fwd_busy, m_ex
    );

    modport master (
        output em_valid, em_pc, em_rf_wdata, em_gr_we, em_dest, em_res_from_mem,
               em_addr, em_ex, em_ecode, em_esubcode, em_csr_addr, em_csr_we,
               em_csr_wmask, em_csr_wdata,
               data_sram_rdata, data_sram_data_ok, w_allowin, ex_en,
        input  m_allowin, mw_valid, mw_pc, mw_rf_wdata, mw_gr_we, mw_dest,
               mw_ex, mw_ecode, mw_esubcode, mw_csr_addr, mw_csr_we,
               mw_csr_wmask, mw_csr_wdata,
               md_fwd_dest, md_fwd_data, md_fwd_busy, m_ex
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds the execute bundle, waits for the
// data-SRAM read response on loads, aligns/extends the loaded value and
// hands the writeback bundle on. A flush (ex_en) kills the held bundle; a
// load still waiting for its response leaves one response to be drained.
//
// Optional build macro: MEM_LOAD_FWD_EN -- when defined, load data is
// forwarded to decode combinationally in the data_ok cycle; otherwise the
// forwarding bus stays busy through that cycle (no SRAM-to-decode path).
//
// state   | meaning
// S_IDLE  | no load outstanding
// S_WAIT  | load issued, response not yet seen
// S_HOLD  | response captured, writeback stalled
// S_DRAIN | flushed while waiting; next data_ok is discarded
module mem_stage #(
    parameter int DATA_W     = 32,
    parameter int CSR_ADDR_W = 14,
    parameter int ECODE_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t                state_q;
    logic                  m_valid_q;
    logic [DATA_W-1:0]     pc_q;
    logic [DATA_W-1:0]     rf_wdata_q;
    logic                  gr_we_q;
    logic [4:0]            dest_q;
    logic [3:0]            res_q;
    logic [1:0]            addr_lo_q;
    logic                  ex_q;
    logic [ECODE_W-1:0]    ecode_q;
    logic                  esubcode_q;
    logic [CSR_ADDR_W-1:0] csr_addr_q;
    logic                  csr_we_q;
    logic [DATA_W-1:0]     csr_wmask_q;
    logic [DATA_W-1:0]     csr_wdata_q;
    logic [DATA_W-1:0]     hold_data_q;

    logic                  is_load;
    logic                  data_ok;
    logic                  ready_go;
    logic                  allowin;
    logic                  in_fire;
    logic                  in_is_load;
    logic [DATA_W-1:0]     load_data_d;
    logic [DATA_W-1:0]     final_wdata;
    logic                  unused_addr_hi;

    // Only the byte offset of the address matters past this point.
    assign unused_addr_hi = ^bus.em_addr[DATA_W-1:2];

    // Select the addressed lane and extend it according to the load type.
    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] word,
                                                     input logic [1:0]        off,
                                                     input logic [3:0]        kind);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[16 +: 16] : word[0 +: 16];
        if (kind[3])
            return word;
        else if (kind[1])
            return kind[2] ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
        else
            return kind[2] ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
    endfunction

    // Handshake and data-path selection.
    always_comb begin
        data_ok     = bus.data_sram_data_ok;
        is_load     = (|res_q) & ~ex_q;
        in_is_load  = (|bus.em_res_from_mem) & ~bus.em_ex;
        ready_go    = !m_valid_q || !is_load
                      || (state_q == S_WAIT && data_ok) || (state_q == S_HOLD);
        allowin     = (state_q != S_DRAIN) && (!m_valid_q || (ready_go && bus.w_allowin));
        in_fire     = bus.em_valid && allowin && !bus.ex_en;
        load_data_d = align_load(bus.data_sram_rdata, addr_lo_q, res_q);
        if (!is_load)
            final_wdata = rf_wdata_q;
        else if (state_q == S_HOLD)
            final_wdata = hold_data_q;
        else
            final_wdata = load_data_d;
    end

    // Bundle register plus load-response FSM; later assignments take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_valid_q   <= 1'b0;
            pc_q        <= '0;
            rf_wdata_q  <= '0;
            gr_we_q     <= 1'b0;
            dest_q      <= '0;
            res_q       <= '0;
            addr_lo_q   <= '0;
            ex_q        <= 1'b0;
            ecode_q     <= '0;
            esubcode_q  <= 1'b0;
            csr_addr_q  <= '0;
            csr_we_q    <= 1'b0;
            csr_wmask_q <= '0;
            csr_wdata_q <= '0;
            hold_data_q <= '0;
        end else begin
            if (bus.ex_en)
                m_valid_q <= 1'b0;
            else if (allowin)
                m_valid_q <= bus.em_valid;

            if (in_fire) begin
                pc_q        <= bus.em_pc;
                rf_wdata_q  <= bus.em_rf_wdata;
                gr_we_q     <= bus.em_gr_we;
                dest_q      <= bus.em_dest;
                res_q       <= bus.em_res_from_mem;
                addr_lo_q   <= bus.em_addr[1:0];
                ex_q        <= bus.em_ex;
                ecode_q     <= bus.em_ecode;
                esubcode_q  <= bus.em_esubcode;
                csr_addr_q  <= bus.em_csr_addr;
                csr_we_q    <= bus.em_csr_we;
                csr_wmask_q <= bus.em_csr_wmask;
                csr_wdata_q <= bus.em_csr_wdata;
            end

            case (state_q)
                S_WAIT: begin
                    // A response arriving with the flush is already consumed.
                    if (bus.ex_en)
                        state_q <= data_ok ? S_IDLE : S_DRAIN;
                    else if (data_ok) begin
                        if (bus.w_allowin)
                            state_q <= S_IDLE;
                        else begin
                            state_q     <= S_HOLD;
                            hold_data_q <= load_data_d;
                        end
                    end
                end
                S_HOLD:  if (bus.ex_en || bus.w_allowin) state_q <= S_IDLE;
                S_DRAIN: if (data_ok) state_q <= S_IDLE;
                default: ;
            endcase

            if (in_fire && in_is_load)
                state_q <= S_WAIT;
        end
    end

    assign bus.m_allowin    = allowin;
    assign bus.mw_valid     = m_valid_q && ready_go && !bus.ex_en;
    assign bus.mw_pc        = pc_q;
    assign bus.mw_rf_wdata  = final_wdata;
    assign bus.mw_gr_we     = gr_we_q;
    assign bus.mw_dest      = dest_q;
    assign bus.mw_ex        = ex_q;
    assign bus.mw_ecode     = ecode_q;
    assign bus.mw_esubcode  = esubcode_q;
    assign bus.mw_csr_addr  = csr_addr_q;
    assign bus.mw_csr_we    = csr_we_q && m_valid_q && !ex_q;
    assign bus.mw_csr_wmask = csr_wmask_q;
    assign bus.mw_csr_wdata = csr_wdata_q;
    assign bus.m_ex         = m_valid_q && ex_q;

    assign bus.md_fwd_dest  = (m_valid_q && gr_we_q) ? dest_q : 5'd0;
    assign bus.md_fwd_data  = final_wdata;
`ifdef MEM_LOAD_FWD_EN
    assign bus.md_fwd_busy  = m_valid_q && is_load && (state_q == S_WAIT) && !data_ok;
`else
    assign bus.md_fwd_busy  = m_valid_q && is_load && (state_q == S_WAIT);
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Accepts the execute-to-memory bundle through a valid/allowin handshake.
- Waits for the data-SRAM read response on loads, then aligns and extends load data.
- Passes the writeback bundle downstream and drives a forwarding bus back to decode; on flush (`ex_en`) it kills in-flight work.

Parameters:
- DATA_W, 32, data/address width
- CSR_ADDR_W, 14, CSR address width
- ECODE_W, 8, exception code width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- em_valid  in  1  execute bundle valid
- m_allowin  out  1  stage can accept a bundle
- em_pc  in  32  instruction PC
- em_rf_wdata  in  32  ALU/CSR result
- em_gr_we  in  1  GPR write enable
- em_dest  in  5  GPR destination
- em_res_from_mem  in  4  load type: [3] word, [2] unsigned, [1] half, [0] byte
- em_addr  in  32  data address
- em_ex  in  1  exception already raised
- em_ecode  in  8  exception code
- em_esubcode  in  1  exception subcode
- em_csr_addr  in  14
- em_csr_we  in  1
- em_csr_wmask  in  32
- em_csr_wdata  in  32
- data_sram_rdata  in  32  read data, valid when data_sram_data_ok
- data_sram_data_ok  in  1  read response strobe
- w_allowin  in  1  writeback can accept
- mw_valid  out  1  bundle to writeback valid
- mw_pc, mw_rf_wdata  out  32 each
- mw_gr_we  out  1
- mw_dest  out  5
- mw_ex  out  1
- mw_ecode  out  8
- mw_esubcode  out  1
- mw_csr_addr  out  14
- mw_csr_we  out  1
- mw_csr_wmask, mw_csr_wdata  out  32 each
- md_fwd_dest  out  5  forwarding destination (0 = none)
- md_fwd_data  out  32  forwarding value
- md_fwd_busy  out  1  dest valid but value not yet available
- ex_en  in  1  pipeline flush (exception/ertn commit)
- m_ex  out  1  this stage holds a valid excepting instruction

Behaviour:
- Reset: all registered bundle fields cleared, state=IDLE. Outputs at reset: mw_valid=0, m_ex=0, md_fwd_dest=0, md_fwd_busy=0, m_allowin=1.
- The bundle register loads when em_valid && m_allowin. m_valid is set to em_valid in that case and cleared when the bundle is handed off without a new one arriving.
- is_load = |res_from_mem & ~ex.
- States:
  - IDLE (no load pending)
  - WAIT (load issued, no data_ok yet)
  - HOLD (data captured, downstream stalled)
- Transitions:
  - Load accepted → WAIT.
  - WAIT & data_ok & w_allowin → IDLE, result passed same cycle.
  - WAIT & data_ok & !w_allowin → HOLD, loaded word registered.
  - HOLD & w_allowin → IDLE.
- m_ready_go = !m_valid | !is_load | (WAIT & data_ok) | HOLD.
- mw_valid = m_valid & m_ready_go & !flush_kill.
- m_allowin = !m_valid | (m_ready_go & w_allowin).
- Load extraction uses addr[1:0]:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Sign-extend unless bit2 is set.
  - word: as-is.
- Non-loads pass em_rf_wdata unchanged.
- ex_en: m_valid cleared next edge. If state is WAIT, the stage enters DRAIN: it swallows exactly one subsequent data_ok, then returns to IDLE. m_allowin=0 while in DRAIN.
- data_ok in IDLE (no DRAIN): ignored.
- Simultaneous em_valid and ex_en: incoming bundle is dropped.
- m_ex = m_valid & em_ex_reg. Exception fields pass unchanged. No memory wait for excepting instructions.
- Forwarding:
  - md_fwd_dest = dest when m_valid & gr_we, else 0.
  - md_fwd_data = final rf_wdata.
  - md_fwd_busy = is_load & (state==WAIT & !data_ok).
- CSR fields registered and forwarded unchanged; csr_we gated by m_valid & !ex.
- Reset mid-WAIT: immediate return to IDLE, no drain.

Optional Feature:
- Macro MEM_LOAD_FWD_EN.
- Defined: load data is forwarded combinationally in the data_ok cycle (md_fwd_busy drops that cycle).
- Undefined: md_fwd_busy stays high in the data_ok cycle and clears only once in HOLD or after handoff. This costs +1 stall but removes the SRAM-to-decode combinational path.

Test Plan:
- lb, addr=0x1003, rdata=0x80FF_1234, data_ok 2 cycles after accept → mw_rf_wdata=0xFFFFFF80, mw_valid 1 cycle, m_allowin=0 during wait.
- lhu, addr=0x2002, rdata=0xBEEF_0001, data_ok with w_allowin=0 for 3 cycles → HOLD, then mw_rf_wdata=0x0000BEEF once w_allowin=1.
- Non-load add, rf_wdata=0x1234, gr_we=1, dest=5 → mw_valid next cycle, md_fwd_dest=5, md_fwd_data=0x1234, md_fwd_busy=0.
- Load in WAIT, ex_en pulse, later stale data_ok, then new add accepted → no mw_valid for the load, stale data dropped, add passes normally.
- Bundle with em_ex=1, ecode=0x09 and res_from_mem=word → m_ex=1, mw_ecode=0x09, no wait for data_ok.
- rst asserted mid-WAIT → mw_valid=0 and m_allowin=1 immediately, asynchronously.
